// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, FSM states,
// byte-enable constants, the store-lane payload and op classification helpers.
package mem_access_unit_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned OP_W      = 4;
   localparam int unsigned BE_W      = 4;
   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned CNT_W     = 16;

   typedef enum logic [OP_W-1:0] {
      MEM_NONE = 4'd0,
      MEM_LB   = 4'd1,
      MEM_LH   = 4'd2,
      MEM_LW   = 4'd3,
      MEM_LBU  = 4'd4,
      MEM_LHU  = 4'd5,
      MEM_SB   = 4'd6,
      MEM_SH   = 4'd7,
      MEM_SW   = 4'd8
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [BE_W-1:0] BE_NONE    = 4'b0000;
   localparam logic [BE_W-1:0] BE_B0      = 4'b0001;
   localparam logic [BE_W-1:0] BE_LO_HALF = 4'b0011;
   localparam logic [BE_W-1:0] BE_HI_HALF = 4'b1100;
   localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;

   // Request-side payload presented on the data-memory port
   typedef struct packed {
      logic            we;
      logic [BE_W-1:0] be;
      logic [XLEN-1:0] wdata;
   } mem_lane_t;

   function automatic logic op_is_load(input logic [OP_W-1:0] op);
      return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
   endfunction

   function automatic logic op_is_store(input logic [OP_W-1:0] op);
      return op inside {MEM_SB, MEM_SH, MEM_SW};
   endfunction

   function automatic logic op_is_half(input logic [OP_W-1:0] op);
      return op inside {MEM_LH, MEM_LHU, MEM_SH};
   endfunction

   function automatic logic op_is_word(input logic [OP_W-1:0] op);
      return op inside {MEM_LW, MEM_SW};
   endfunction

   // Byte enables and lane-replicated data; loads read the whole word
   function automatic mem_lane_t lane_encode(input logic [OP_W-1:0] op,
                                             input logic [1:0]      a,
                                             input logic [XLEN-1:0] rs2);
      mem_lane_t lane;
      lane.we    = 1'b0;
      lane.be    = BE_WORD;
      lane.wdata = '0;
      case (op)
         MEM_SB: begin
            lane.we    = 1'b1;
            lane.be    = BE_B0 << a;
            lane.wdata = {4{rs2[7:0]}};
         end
         MEM_SH: begin
            lane.we    = 1'b1;
            lane.be    = a[1] ? BE_HI_HALF : BE_LO_HALF;
            lane.wdata = {2{rs2[15:0]}};
         end
         MEM_SW: begin
            lane.we    = 1'b1;
            lane.be    = BE_WORD;
            lane.wdata = rs2;
         end
         default: begin
            lane.we    = 1'b0;
            lane.be    = BE_WORD;
            lane.wdata = '0;
         end
      endcase
      return lane;
   endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load alignment: picks the byte/halfword lane of the read word and
// sign- or zero-extends it to 32 bits. Purely combinational.
module load_align
   import mem_access_unit_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [OP_W-1:0] op,
   input  logic [1:0]      a,
   output logic [XLEN-1:0] rdata_ext_c
);

   logic [7:0]  byte_c;
   logic [15:0] half_c;

   // Lane selection followed by extension according to the load type
   always_comb begin
      byte_c      = rdata[7:0];
      half_c      = a[1] ? rdata[31:16] : rdata[15:0];
      rdata_ext_c = rdata;
      case (a)
         2'd0: byte_c = rdata[7:0];
         2'd1: byte_c = rdata[15:8];
         2'd2: byte_c = rdata[23:16];
         2'd3: byte_c = rdata[31:24];
         default: byte_c = rdata[7:0];
      endcase
      case (op)
         MEM_LB:  rdata_ext_c = {{24{byte_c[7]}}, byte_c};
         MEM_LBU: rdata_ext_c = {24'h0, byte_c};
         MEM_LH:  rdata_ext_c = {{16{half_c[15]}}, half_c};
         MEM_LHU: rdata_ext_c = {16'h0, half_c};
         default: rdata_ext_c = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues request/ack data-memory accesses, stalls
// the pipeline while an access is outstanding, aborts after BUS_TIMEOUT wait
// cycles, and hands the aligned load result to MEM/WB.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned halfword/word accesses
// are not issued and are flagged on misalign_o instead.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned BUS_TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [OP_W-1:0]      mem_op_i,
   input  logic [ADDR_W-1:0]    addr_i,
   input  logic [XLEN-1:0]      wdata_i,
   input  logic                 wd_i,
   input  logic [RF_ADDR_W-1:0] wreg_i,
   output logic                 wd_o,
   output logic [RF_ADDR_W-1:0] wreg_o,
   output logic [XLEN-1:0]      wdata_o,
   output logic                 me_stall_req_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [BE_W-1:0]      mem_be_o,
   output logic [XLEN-1:0]      mem_wdata_o,
   input  logic [XLEN-1:0]      mem_rdata_i,
   input  logic                 mem_ack_i,
   output logic                 bus_err_o
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic                 misalign_o
`endif
);

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BUS_TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   res_q, res_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [1:0]        a_q, a_d;

   logic              req_d, we_d, err_d;
   logic [ADDR_W-1:0] addr_d;
   logic [BE_W-1:0]   be_d;
   logic [XLEN-1:0]   wdata_d;

   logic              is_mem_c;
   logic              issue_c;
   mem_lane_t         lane_c;
   logic [XLEN-1:0]   ext_c;

   assign is_mem_c = op_is_load(mem_op_i) | op_is_store(mem_op_i);
   assign lane_c   = lane_encode(mem_op_i, addr_i[1:0], wdata_i);

`ifdef MEM_MISALIGN_TRAP_EN
   logic misalign_c;
   assign misalign_c = (op_is_half(mem_op_i) & addr_i[0]) |
                       (op_is_word(mem_op_i) & (addr_i[1:0] != 2'b00));
   assign issue_c    = is_mem_c & ~misalign_c;
`else
   assign issue_c    = is_mem_c;
`endif

   // Aligned load result from the latched op and address lane
   load_align u_load_align (
      .rdata       (mem_rdata_i),
      .op          (op_q),
      .a           (a_q),
      .rdata_ext_c (ext_c)
   );

   // State and registered bus-side outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         res_q       <= '0;
         op_q        <= OP_W'(MEM_NONE);
         a_q         <= '0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_be_o    <= BE_NONE;
         mem_wdata_o <= '0;
         bus_err_o   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         res_q       <= res_d;
         op_q        <= op_d;
         a_q         <= a_d;
         mem_req_o   <= req_d;
         mem_we_o    <= we_d;
         mem_addr_o  <= addr_d;
         mem_be_o    <= be_d;
         mem_wdata_o <= wdata_d;
         bus_err_o   <= err_d;
      end
   end

   // Next state, bus request set-up, and the combinational MEM/WB-side outputs
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      res_d          = res_q;
      op_d           = op_q;
      a_d            = a_q;
      req_d          = mem_req_o;
      we_d           = mem_we_o;
      addr_d         = mem_addr_o;
      be_d           = mem_be_o;
      wdata_d        = mem_wdata_o;
      err_d          = 1'b0;
      wd_o           = 1'b0;
      wreg_o         = wreg_i;
      wdata_o        = wdata_i;
      me_stall_req_o = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o     = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_o = misalign_c;
`endif
            if (issue_c) begin
               me_stall_req_o = 1'b1;
               state_d        = ST_WAIT;
               cnt_d          = '0;
               op_d           = mem_op_i;
               a_d            = addr_i[1:0];
               req_d          = 1'b1;
               we_d           = lane_c.we;
               addr_d         = {addr_i[ADDR_W-1:2], 2'b00};
               be_d           = lane_c.be;
               wdata_d        = lane_c.wdata;
            end else if (!is_mem_c) begin
               wd_o = wd_i;
            end
         end
         ST_WAIT: begin
            me_stall_req_o = 1'b1;
            if (mem_ack_i) begin
               res_d   = op_is_load(op_q) ? ext_c : '0;
               req_d   = 1'b0;
               state_d = ST_DONE;
            end else if (cnt_q == TMO_LAST) begin
               res_d   = '0;
               req_d   = 1'b0;
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            wdata_o = res_q;
            wd_o    = op_is_load(op_q) ? wd_i : 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Nothing reaches WB or the stall controller while reset is held
      if (rst) begin
         wd_o           = 1'b0;
         wreg_o         = '0;
         wdata_o        = '0;
         me_stall_req_o = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_o     = 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver issues accesses and queues the
// expected bus request and writeback; a memory responder acks after a chosen
// latency; a monitor pops and compares on every bus request and retirement.
module tb_mem_access_unit;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned TMO    = 4;

   localparam logic [3:0] OP_NONE = 4'd0;
   localparam logic [3:0] OP_LB   = 4'd1;
   localparam logic [3:0] OP_LH   = 4'd2;
   localparam logic [3:0] OP_LW   = 4'd3;
   localparam logic [3:0] OP_LBU  = 4'd4;
   localparam logic [3:0] OP_LHU  = 4'd5;
   localparam logic [3:0] OP_SB   = 4'd6;
   localparam logic [3:0] OP_SH   = 4'd7;
   localparam logic [3:0] OP_SW   = 4'd8;

   logic        clk         = 1'b0;
   logic        rst         = 1'b1;
   logic [3:0]  mem_op_i    = '0;
   logic [31:0] addr_i      = '0;
   logic [31:0] wdata_i     = '0;
   logic        wd_i        = 1'b0;
   logic [4:0]  wreg_i      = '0;
   logic [31:0] mem_rdata_i = '0;
   logic        mem_ack_i   = 1'b0;
   logic        wd_o;
   logic [4:0]  wreg_o;
   logic [31:0] wdata_o;
   logic        me_stall_req_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        bus_err_o;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign_o;
`endif

   mem_access_unit #(.ADDR_W(ADDR_W), .BUS_TIMEOUT(TMO)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_op_i       (mem_op_i),
      .addr_i         (addr_i),
      .wdata_i        (wdata_i),
      .wd_i           (wd_i),
      .wreg_i         (wreg_i),
      .wd_o           (wd_o),
      .wreg_o         (wreg_o),
      .wdata_o        (wdata_o),
      .me_stall_req_o (me_stall_req_o),
      .mem_req_o      (mem_req_o),
      .mem_we_o       (mem_we_o),
      .mem_addr_o     (mem_addr_o),
      .mem_be_o       (mem_be_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_rdata_i    (mem_rdata_i),
      .mem_ack_i      (mem_ack_i),
      .bus_err_o      (bus_err_o)
`ifdef MEM_MISALIGN_TRAP_EN
      ,
      .misalign_o     (misalign_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_exp_t;

   typedef struct {
      logic        wd;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      logic        chk_data;
      logic        err;
      logic        mis;
      int          stalls;
   } wb_exp_t;

   req_exp_t    req_q[$];
   wb_exp_t     wb_q[$];
   int          checks     = 0;
   int          failures   = 0;
   int          ack_lat    = 0;
   logic [31:0] rdata_next = '0;
   bit          mon_en     = 1'b0;
   bit          abort      = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference load result from byte/halfword arithmetic on the read word
   function automatic logic [31:0] load_val(input logic [3:0] op, input int a, input logic [31:0] rd);
      logic [31:0] b;
      logic [31:0] h;
      b = (rd >> (8 * a)) & 32'h0000_00FF;
      h = (rd >> (16 * (a / 2))) & 32'h0000_FFFF;
      case (op)
         OP_LB:   return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
         OP_LBU:  return b;
         OP_LH:   return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
         OP_LHU:  return h;
         default: return rd;
      endcase
   endfunction

   // Memory responder: ack after ack_lat request cycles (0 = never); random ack noise when idle
   int wcnt = 0;
   always @(negedge clk) begin
      if (rst) begin
         wcnt      = 0;
         mem_ack_i = 1'b0;
      end else if (mem_req_o) begin
         wcnt++;
         if (ack_lat > 0 && wcnt == ack_lat) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = rdata_next;
         end else begin
            mem_ack_i   = 1'b0;
            mem_rdata_i = $urandom;
         end
      end else begin
         wcnt        = 0;
         mem_ack_i   = 1'($urandom_range(0, 1));
         mem_rdata_i = $urandom;
      end
   end

   // Monitor: compares bus requests and each retirement against the queues
   req_exp_t cur;
   wb_exp_t  w;
   logic     prev_req  = 1'b0;
   int       stall_run = 0;
   always @(negedge clk) begin
      if (rst || !mon_en) begin
         prev_req  = 1'b0;
         stall_run = 0;
      end else begin
         if (mem_req_o) begin
            if (!prev_req) begin
               if (req_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_req actual_addr=0x%08h required=no_request", mem_addr_o);
               end else begin
                  cur = req_q.pop_front();
               end
            end
            chk("req_we",   32'(mem_we_o),   32'(cur.we));
            chk("req_addr", mem_addr_o,      cur.addr);
            chk("req_be",   32'(mem_be_o),   32'(cur.be));
            if (cur.we) chk("req_wdata", mem_wdata_o, cur.wdata);
         end
         prev_req = mem_req_o;
         if (me_stall_req_o) begin
            stall_run++;
            chk("stall_wd",  32'(wd_o),      32'd0);
            chk("stall_err", 32'(bus_err_o), 32'd0);
         end else if (wb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_retire actual_wd=%0d required=no_retire", wd_o);
         end else begin
            w = wb_q.pop_front();
            chk("wb_wd",   32'(wd_o),      32'(w.wd));
            chk("wb_wreg", 32'(wreg_o),    32'(w.wreg));
            if (w.chk_data) chk("wb_wdata", wdata_o, w.wdata);
            chk("wb_err",  32'(bus_err_o), 32'(w.err));
            chk("stall_cycles", 32'(stall_run), 32'(w.stalls));
`ifdef MEM_MISALIGN_TRAP_EN
            chk("misalign", 32'(misalign_o), 32'(w.mis));
`endif
            stall_run = 0;
         end
      end
   end

   // Queue the expected response, present the instruction, wait for it to retire
   task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                        input logic wd, input logic [4:0] wreg, input logic [31:0] rd, input int lat);
      req_exp_t r;
      wb_exp_t  e;
      int       a;
      bit       ld, st, tmo, mis, done;
      if (abort) return;
      a   = int'(addr[1:0]);
      ld  = (op >= OP_LB) && (op <= OP_LHU);
      st  = (op >= OP_SB) && (op <= OP_SW);
      tmo = (lat <= 0) || (lat > int'(TMO));
      mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis = ((op == OP_LH || op == OP_LHU || op == OP_SH) && (a % 2 == 1)) ||
            ((op == OP_LW || op == OP_SW) && (a != 0));
`endif
      e.wreg = wreg;
      e.mis  = mis;
      if ((ld || st) && !mis) begin
         r.we    = st;
         r.addr  = addr & 32'hFFFF_FFFC;
         r.be    = 4'hF;
         r.wdata = 32'h0;
         if (op == OP_SB) begin
            r.be    = 4'(1 << a);
            r.wdata = {24'h0, rs2[7:0]} * 32'h0101_0101;
         end else if (op == OP_SH) begin
            r.be    = (a >= 2) ? 4'hC : 4'h3;
            r.wdata = {16'h0, rs2[15:0]} * 32'h0001_0001;
         end else if (op == OP_SW) begin
            r.wdata = rs2;
         end
         req_q.push_back(r);
         e.stalls   = 1 + (tmo ? int'(TMO) : lat);
         e.err      = tmo;
         e.wd       = ld ? wd : 1'b0;
         e.chk_data = ld;
         e.wdata    = tmo ? 32'h0 : load_val(op, a, rd);
      end else if (mis) begin
         e.stalls   = 0;
         e.err      = 1'b0;
         e.wd       = 1'b0;
         e.chk_data = 1'b0;
         e.wdata    = 32'h0;
      end else begin
         e.stalls   = 0;
         e.err      = 1'b0;
         e.wd       = wd;
         e.chk_data = 1'b1;
         e.wdata    = rs2;
      end
      wb_q.push_back(e);
      mem_op_i   = op;
      addr_i     = addr;
      wdata_i    = rs2;
      wd_i       = wd;
      wreg_i     = wreg;
      ack_lat    = lat;
      rdata_next = rd;
      done       = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!me_stall_req_o) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL retire_timeout actual=still_stalled required=retire_within_40_cycles op=%0d", op);
         abort = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   // Reset asserted in the second WAIT cycle must drop the request at once
   task automatic reset_in_wait();
      req_exp_t r;
      r.we    = 1'b0;
      r.addr  = 32'h0000_0300;
      r.be    = 4'hF;
      r.wdata = 32'h0;
      req_q.push_back(r);
      mem_op_i = OP_LW;
      addr_i   = 32'h0000_0300;
      wd_i     = 1'b1;
      wreg_i   = 5'd9;
      ack_lat  = 0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_wait_req",   32'(mem_req_o),      32'd0);
      chk("rst_wait_stall", 32'(me_stall_req_o), 32'd0);
      chk("rst_wait_err",   32'(bus_err_o),      32'd0);
      chk("rst_wait_wd",    32'(wd_o),           32'd0);
      req_q.delete();
      wb_q.delete();
      mem_op_i = OP_NONE;
      @(posedge clk);
      #1;
      chk("rst_hold_err", 32'(bus_err_o), 32'd0);
      chk("rst_hold_req", 32'(mem_req_o), 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      mem_op_i = OP_LW;
      addr_i   = 32'h0000_0100;
      wdata_i  = 32'hDEAD_BEEF;
      wd_i     = 1'b1;
      wreg_i   = 5'd7;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_req",   32'(mem_req_o),      32'd0);
      chk("reset_we",    32'(mem_we_o),       32'd0);
      chk("reset_be",    32'(mem_be_o),       32'd0);
      chk("reset_addr",  mem_addr_o,          32'd0);
      chk("reset_mwdat", mem_wdata_o,         32'd0);
      chk("reset_err",   32'(bus_err_o),      32'd0);
      chk("reset_wd",    32'(wd_o),           32'd0);
      chk("reset_wreg",  32'(wreg_o),         32'd0);
      chk("reset_wdata", wdata_o,             32'd0);
      chk("reset_stall", 32'(me_stall_req_o), 32'd0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      issue(OP_NONE, 32'h0, 32'h0000_1234, 1'b1, 5'd5, 32'h0, 0);
      issue(OP_LW,  32'h0000_0100, 32'h0, 1'b1, 5'd3, 32'hCAFE_F00D, 3);
      issue(OP_LB,  32'h0000_0103, 32'h0, 1'b1, 5'd4, 32'h8000_0000, 1);
      issue(OP_LBU, 32'h0000_0103, 32'h0, 1'b1, 5'd4, 32'h8000_0000, 2);
      issue(OP_SB,  32'h0000_0102, 32'h0000_00AB, 1'b1, 5'd6, 32'h0, 2);
      issue(OP_LH,  32'h0000_0042, 32'h0, 1'b1, 5'd8, 32'h9876_5432, 4);
      issue(OP_SH,  32'h0000_0046, 32'h1234_BEEF, 1'b0, 5'd2, 32'h0, 1);
      issue(OP_LW,  32'h0000_0200, 32'h0, 1'b1, 5'd7, 32'h1111_2222, 0);
      issue(OP_SW,  32'h0000_0204, 32'h5555_AAAA, 1'b1, 5'd1, 32'h0, 0);
      issue(4'd9,   32'h0000_0104, 32'h0BAD_0009, 1'b1, 5'd10, 32'h0, 1);
      issue(4'd15,  32'h0000_0108, 32'h0BAD_000F, 1'b0, 5'd11, 32'h0, 1);
`ifdef MEM_MISALIGN_TRAP_EN
      issue(OP_LW,  32'h0000_0102, 32'h0, 1'b1, 5'd12, 32'h0, 1);
`endif
      if (!abort) reset_in_wait();

      for (int n = 0; n < 150 && !abort; n++) begin
         issue(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, 5)));
      end
      mon_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store unit of the 5-stage RV32I pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It drives a request/acknowledge data-memory port and generates me_stall_req_o for the pipeline stall controller. It performs lane alignment and byte enables for stores, and byte extraction with sign or zero extension for loads.

Parameters:
ADDR_W, 32, width of the data address.
BUS_TIMEOUT, 255, maximum WAIT cycles before the access is aborted (1..65535).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
mem_op_i  in  4  0=none, 1=LB, 2=LH, 3=LW, 4=LBU, 5=LHU, 6=SB, 7=SH, 8=SW; codes 9-15 are treated as none
addr_i  in  ADDR_W  effective address from EX
wdata_i  in  32  for stores: rs2 value; for non-memory ops: ALU result
wd_i  in  1  register-write enable from EX
wreg_i  in  5  destination register
wd_o  out  1  register-write enable to MEM/WB
wreg_o  out  5  destination register to MEM/WB
wdata_o  out  32  writeback data to MEM/WB
me_stall_req_o  out  1  stall request to the stall controller
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write
mem_addr_o  out  ADDR_W  word-aligned address ({addr_i[ADDR_W-1:2],2'b00})
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  lane-replicated store data
mem_rdata_i  in  32  read data, valid when mem_ack_i=1
mem_ack_i  in  1  access complete
bus_err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset, applied asynchronously: state=IDLE; mem_req_o, mem_we_o, mem_be_o, bus_err_o, wd_o = 0; mem_addr_o, mem_wdata_o, wdata_o = 0; wreg_o = 0; timeout counter = 0.
- States: IDLE, WAIT, DONE.
- me_stall_req_o is combinational: 1 when (state==IDLE and mem_op_i is a load/store) or state==WAIT; otherwise 0.
- IDLE, no memory op:
  - wd_o, wreg_o and wdata_o pass wd_i, wreg_i and wdata_i combinationally.
  - The FSM stays in IDLE.
- IDLE, memory op:
  - wd_o=0, so a bubble goes to WB.
  - Registered at the next edge: mem_req_o=1, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o; the counter clears; the FSM goes to WAIT.
- WAIT:
  - mem_req_o and all address/data/enable outputs are held stable.
  - mem_ack_i=1: capture the aligned load result; drop mem_req_o at the edge; go to DONE.
  - Ack is sampled only in WAIT, so minimum latency is 2 stall cycles plus the DONE cycle.
  - No ack: the counter increments. When the counter reaches BUS_TIMEOUT-1 without ack: drop the request, pulse bus_err_o for 1 cycle, set the captured result to 0, go to DONE.
- DONE:
  - me_stall_req_o=0.
  - wdata_o = captured result; wd_o = wd_i for loads and 0 for stores; wreg_o = wreg_i.
  - The FSM returns to IDLE. The pipeline advances at this edge, so the same access is never reissued.
- Store encoding (a = addr_i[1:0]):
  - SB: be = 4'b0001<<a; data = {4{rs2[7:0]}}.
  - SH: be = a[1] ? 4'b1100 : 4'b0011; data = {2{rs2[15:0]}}.
  - SW: be = 4'b1111; data = rs2.
- Load encoding (a = addr_i[1:0]):
  - be = 4'b1111.
  - LB/LBU: byte lane a, sign- or zero-extended.
  - LH/LHU: halfword lane a[1], sign- or zero-extended.
  - LW: the full word.
- Misaligned addresses (macro absent): the low bits are ignored as above (SH/LH use a[1]; LW/SW force alignment).
- mem_ack_i outside WAIT is ignored.
- An asynchronous reset in WAIT aborts immediately: mem_req_o=0 and no bus_err_o pulse.

Optional Feature:
MEM_MISALIGN_TRAP_EN.
- Defined:
  - A halfword access with a[0]=1, or a word access with a≠0, issues no bus request and raises no stall.
  - Output misalign_o (1 bit, combinational) is 1 for that cycle, and wd_o=0.
- Absent: misalign_o does not exist and the alignment-ignoring rule applies.

Decomposition:
- Shared package holds:
  - the mem_op codes (MEM_NONE..MEM_SW);
  - the FSM state encoding;
  - the byte-enable constants.
- Sub-module load_align (combinational) takes rdata, op and a, and produces the extended 32-bit result; it is instantiated once.

Test Plan:
- Non-memory op (0), wdata_i=0x1234, wd_i=1 -> wdata_o=0x1234 in the same cycle, me_stall_req_o=0, mem_req_o=0.
- LW at 0x100, ack 3 cycles after the request -> mem_addr_o=0x100, be=1111; stall high for 4 cycles; DONE cycle wdata_o=rdata, wd_o=1.
- LB at 0x103, rdata=0x80000000 -> wdata_o=0xFFFFFF80; LBU at the same address -> 0x00000080.
- SB at 0x102, rs2=0xAB -> be=0100, mem_wdata_o=0xABABABAB, we=1; DONE cycle wd_o=0.
- No ack with BUS_TIMEOUT=4 -> bus_err_o single pulse; DONE cycle wdata_o=0; return to IDLE.
- Assert rst in the 2nd WAIT cycle -> mem_req_o=0 and stall=0 immediately. With MEM_MISALIGN_TRAP_EN: LW at 0x102 -> misalign_o=1, no request.
